// File: rtl/darkbus_mem_cons.sv
// Darkbus consumer responder: byte-writable word memory behind one consumer port,
// with address-window decode, programmable wait states and registered RACK/WACK.
module darkbus_mem_cons #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter logic [31:0] MASK      = 32'hFFFF_F000,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 0
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        EN,
  input  logic        RE,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] ADDR,
  inout  wire  [31:0] DATA,
  output logic        RACK,
  output logic        WACK
);

  localparam int DEPTH = 1 << ADDR_BITS;

  if (RD_LAT < 0 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("darkbus_mem_cons: RD_LAT must be within 0..7");
  end
  if (WR_LAT < 0 || WR_LAT > 7) begin : g_bad_wr_lat
    $error("darkbus_mem_cons: WR_LAT must be within 0..7");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
    $error("darkbus_mem_cons: ADDR_BITS must be within 1..30");
  end

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);
  localparam logic [2:0] WR_LAT_C = 3'(WR_LAT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

  state_t               state_reg, state_next;
  logic [2:0]           cnt_reg, cnt_next;
  logic [ADDR_BITS-1:0] idx_reg;
  logic [3:0]           be_reg;
  logic [31:0]          wdata_reg;
  logic                 write_reg;
  logic                 rack_reg, wack_reg, drive_reg;
  logic                 rack_next, wack_next, drive_next;
  logic [31:0]          rdata;
  logic                 hit, req, capture;
  logic [2:0]           lat_sel;

  assign hit     = (ADDR & MASK) == BASE;
  assign req     = EN & (RE | WE) & hit;
  // A request with both strobes is a write, so it takes the write latency.
  assign lat_sel = WE ? WR_LAT_C : RD_LAT_C;
  assign capture = (state_reg == ST_IDLE) && req;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      rack_reg  <= 1'b0;
      wack_reg  <= 1'b0;
      drive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        idx_reg   <= ADDR[ADDR_BITS+1:2];
        be_reg    <= BE;
        wdata_reg <= DATA;
        write_reg <= WE;
      end
      rack_reg  <= rack_next;
      wack_reg  <= wack_next;
      drive_reg <= drive_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          cnt_next   = lat_sel;
          state_next = (lat_sel == 3'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!EN) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg <= 3'd1) state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_HOLD;
        cnt_next   = '0;
      end
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Ack strobes are decided in ACK and registered, so they appear one cycle later.
  always_comb begin
    rack_next  = 1'b0;
    wack_next  = 1'b0;
    drive_next = 1'b0;
    if (state_reg == ST_ACK) begin
      rack_next  = !write_reg;
      drive_next = !write_reg;
      wack_next  = write_reg;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane [DEPTH];
    logic [7:0] rd_lane;

    always_ff @(posedge CLK) begin
      if (state_reg == ST_ACK) begin
        if (write_reg) begin
          if (be_reg[gi]) lane[idx_reg] <= wdata_reg[8*gi +: 8];
        end else begin
          rd_lane <= lane[idx_reg];
        end
      end
    end

    assign rdata[8*gi +: 8] = rd_lane;
  end

  assign DATA = drive_reg ? rdata : 'z;
  assign RACK = rack_reg;
  assign WACK = wack_reg;

  // Provider must hold its request steady while wait states run.
  property p_request_stable;
    @(posedge CLK) disable iff (!RESn)
      (state_reg == ST_WAIT && EN) |->
        (ADDR[ADDR_BITS+1:2] == idx_reg && BE == be_reg && WE == write_reg &&
         (RE | WE) && (!write_reg || DATA == wdata_reg));
  endproperty
  assert property (p_request_stable);

  property p_single_ack;
    @(posedge CLK) disable iff (!RESn) !(rack_reg && wack_reg);
  endproperty
  assert property (p_single_ack);

endmodule

// File: tb/tb_darkbus_mem_cons.sv
// Bench for darkbus_mem_cons: three responders with different latencies, directed
// requests push expected acks into a scoreboard that a negedge monitor drains.
module tb_darkbus_mem_cons;

  localparam int NU = 3;

  function automatic int rd_lat_of(input int u);
    case (u)
      0:       return 1;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int wr_lat_of(input int u);
    case (u)
      0:       return 0;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NU-1:0]        en, re, we, drv;
  logic [NU-1:0]        rack, wack;
  logic [NU-1:0][3:0]   be;
  logic [NU-1:0][31:0]  addr, wdat, bus_val;
  int                   cyc = 0;
  int                   checks = 0;
  int                   errors = 0;

  typedef struct {
    int          unit;
    bit          is_read;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NU; gi++) begin : g_u
    wire [31:0] data_bus;
    assign data_bus    = drv[gi] ? wdat[gi] : 'z;
    assign bus_val[gi] = data_bus;

    darkbus_mem_cons #(
      .ADDR_BITS(10),
      .BASE     (32'h0000_0000),
      .MASK     (32'hFFFF_F000),
      .RD_LAT   (rd_lat_of(gi)),
      .WR_LAT   (wr_lat_of(gi))
    ) u_dut (
      .CLK (clk),
      .RESn(rst_n),
      .EN  (en[gi]),
      .RE  (re[gi]),
      .WE  (we[gi]),
      .BE  (be[gi]),
      .ADDR(addr[gi]),
      .DATA(data_bus),
      .RACK(rack[gi]),
      .WACK(wack[gi])
    );
  end

  // Undriven bus reads as z in four-state simulators and as 0 in two-state ones.
  function automatic bit released(input logic [31:0] v);
    return $isunknown(v) || (v == 32'h0);
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s unit=%0d cyc=%0d got=%h required=%h", name, u, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rack[u] || wack[u]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack unit=%0d cyc=%0d got rack=%0b wack=%0b required no ack",
                   u, cyc, rack[u], wack[u]);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_unit", u, 32'(mon_e.unit), 32'(u));
          chk("ack_kind", u, {30'b0, rack[u], wack[u]}, {30'b0, mon_e.is_read, !mon_e.is_read});
          chk("ack_cycle", u, 32'(cyc), 32'(mon_e.at));
          if (mon_e.is_read) chk("read_data", u, bus_val[u], mon_e.data);
        end
      end
      if (!rack[u] && !drv[u]) begin
        checks++;
        if (!released(bus_val[u])) begin
          errors++;
          $display("FAIL bus_release unit=%0d cyc=%0d got=%h required=z", u, cyc, bus_val[u]);
        end
      end
    end
  end

  // One provider transaction; ack is expected 2+LAT cycles after the driving edge.
  task automatic issue(input int u, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input bit expect_ack,
                       input logic [31:0] exp_rd, input bit extra_hold);
    int lat;
    bit got;
    @(posedge clk); #1;
    en[u] = 1'b1; re[u] = r; we[u] = w; addr[u] = a; be[u] = b; wdat[u] = d; drv[u] = w;
    lat = w ? wr_lat_of(u) : rd_lat_of(u);
    if (expect_ack) sb.push_back('{u, !w, exp_rd, cyc + 2 + lat});
    $display("xact unit=%0d re=%0b we=%0b addr=%h be=%h wdata=%h expect_ack=%0b exp_rd=%h",
             u, r, w, a, b, d, expect_ack, exp_rd);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = rack[u] | wack[u];
    end
    if (got && extra_hold) begin
      @(posedge clk); #1;
    end
    en[u] = 1'b0; re[u] = 1'b0; we[u] = 1'b0; drv[u] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0; re = '0; we = '0; drv = '0; be = '0; addr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // unit 0: RD_LAT=1, WR_LAT=0
    issue(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1, 32'h0, 0);
    issue(0, 1, 0, 32'h10, 4'hF, 32'h0,        1, 32'hDEADBEEF, 0);
    issue(0, 0, 1, 32'h20, 4'hF, 32'h11223344, 1, 32'h0, 0);
    issue(0, 0, 1, 32'h20, 4'h5, 32'hAABBCCDD, 1, 32'h0, 0);
    issue(0, 1, 0, 32'h20, 4'hF, 32'h0,        1, 32'h11BB33DD, 0);
    issue(0, 0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, 1, 32'h0, 0);
    issue(0, 1, 0, 32'h22, 4'hF, 32'h0,        1, 32'h11BB33DD, 0);
    issue(0, 1, 0, 32'h1000, 4'hF, 32'h0,      0, 32'h0, 0);
    issue(0, 0, 1, 32'h2010, 4'hF, 32'h00000099, 0, 32'h0, 0);
    issue(0, 1, 1, 32'h30, 4'hF, 32'h00000005, 1, 32'h0, 0);
    issue(0, 1, 0, 32'h30, 4'hF, 32'h0,        1, 32'h00000005, 0);
    issue(0, 0, 1, 32'h33, 4'h8, 32'h77000000, 1, 32'h0, 0);
    issue(0, 1, 0, 32'h30, 4'hF, 32'h0,        1, 32'h77000005, 0);
    issue(0, 1, 0, 32'h10, 4'hF, 32'h0,        1, 32'hDEADBEEF, 1);

    // unit 1: RD_LAT=4, WR_LAT=3
    issue(1, 0, 1, 32'h40, 4'hF, 32'h12345678, 1, 32'h0, 0);
    @(posedge clk); #1;
    en[1] = 1'b1; re[1] = 1'b1; addr[1] = 32'h40; be[1] = 4'hF;
    $display("xact unit=1 read addr=00000040 aborted in wait, expect no ack");
    repeat (2) @(posedge clk); #1;
    en[1] = 1'b0; re[1] = 1'b0;
    repeat (10) @(posedge clk);
    issue(1, 1, 0, 32'h40, 4'hF, 32'h0, 1, 32'h12345678, 0);

    @(posedge clk); #1;
    en[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; be[1] = 4'hF; wdat[1] = 32'hCAFEF00D; drv[1] = 1'b1;
    $display("xact unit=1 write addr=00000040 wdata=cafef00d reset in wait, expect no ack");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    en[1] = 1'b0; we[1] = 1'b0; drv[1] = 1'b0; rst_n = 1'b1;
    repeat (8) @(posedge clk);
    issue(1, 1, 0, 32'h40, 4'hF, 32'h0, 1, 32'h12345678, 0);

    // unit 2: zero latency, EN held continuously gives an ack every third cycle
    issue(2, 0, 1, 32'h8, 4'hF, 32'h0BADCAFE, 1, 32'h0, 0);
    @(posedge clk); #1;
    en[2] = 1'b1; re[2] = 1'b1; addr[2] = 32'h8; be[2] = 4'hF;
    for (int k = 0; k < 3; k++) sb.push_back('{2, 1'b1, 32'h0BADCAFE, cyc + 2 + 3 * k});
    $display("xact unit=2 back-to-back reads addr=00000008 expect 3 acks of 0badcafe");
    repeat (9) @(posedge clk); #1;
    en[2] = 1'b0; re[2] = 1'b0;

    repeat (10) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_ack got pending=%0d required pending=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got cyc=%0d required completion", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
